// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU/branch unit, EX/MEM register.
// Define EXEC_MUL_EN to add the iterative shift-add multiplier that stalls the front end.
module execute_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWriteE,
   input  logic            MemWriteE,
   input  logic            JumpE,
   input  logic            BranchE,
   input  logic            ALUSrcE,
   input  logic [1:0]      ResultSrcE,
   input  logic [2:0]      Funct3E,
   input  logic [3:0]      ALUControlE,
   input  logic [XLEN-1:0] RD1E,
   input  logic [XLEN-1:0] RD2E,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] ImmExtE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [RA_W-1:0] RdE,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] ResultW,
   input  logic            FlushE,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            StallE,
   output logic            RegWriteM,
   output logic            MemWriteM,
   output logic [1:0]      ResultSrcM,
   output logic [RA_W-1:0] RdM,
   output logic [XLEN-1:0] ALUResultM,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] PCPlus4M
);

   localparam int SH_W = $clog2(XLEN);

   logic [XLEN-1:0]        src_a, src_b, write_data, alu_res;
   logic signed [XLEN-1:0] src_a_s, src_b_s;
   logic                   eq, lt_s, lt_u, taken, is_mul;
   logic                   mul_done;
   logic [XLEN-1:0]        mul_res;
   logic [SH_W-1:0]        shamt;

   always_comb begin
      case (ForwardAE)
         2'b01:   src_a = ResultW;
         2'b10:   src_a = ALUResultM;
         default: src_a = RD1E;
      endcase
      case (ForwardBE)
         2'b01:   write_data = ResultW;
         2'b10:   write_data = ALUResultM;
         default: write_data = RD2E;
      endcase
   end

   assign src_b   = ALUSrcE ? ImmExtE : write_data;
   assign src_a_s = src_a;
   assign src_b_s = src_b;
   assign shamt   = src_b[SH_W-1:0];
   assign eq      = (src_a == src_b);
   assign lt_s    = (src_a_s < src_b_s);
   assign lt_u    = (src_a < src_b);
   assign is_mul  = (ALUControlE == 4'b1010);

   always_comb begin
      alu_res = '0;
      case (ALUControlE)
         4'b0000: alu_res = src_a + src_b;
         4'b0001: alu_res = src_a - src_b;
         4'b0010: alu_res = src_a & src_b;
         4'b0011: alu_res = src_a | src_b;
         4'b0100: alu_res = src_a ^ src_b;
         4'b0101: alu_res = {{(XLEN-1){1'b0}}, lt_s};
         4'b0110: alu_res = {{(XLEN-1){1'b0}}, lt_u};
         4'b0111: alu_res = src_a << shamt;
         4'b1000: alu_res = src_a >> shamt;
         4'b1001: alu_res = src_a_s >>> shamt;
         4'b1010: alu_res = mul_done ? mul_res : '0;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      case (Funct3E)
         3'b000:  taken = eq;
         3'b001:  taken = !eq;
         3'b100:  taken = lt_s;
         3'b101:  taken = !lt_s;
         3'b110:  taken = lt_u;
         3'b111:  taken = !lt_u;
         default: taken = 1'b0;
      endcase
   end

   assign PCSrcE    = !FlushE && (JumpE || (BranchE && taken));
   assign PCTargetE = PCE + ImmExtE;

`ifdef EXEC_MUL_EN
   typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

   mul_state_e      state_q, state_d;
   logic [XLEN-1:0] ma_q, ma_d, mb_q, mb_d, acc_q, acc_d;
   logic [SH_W-1:0] cnt_q, cnt_d;
   logic            stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Operand/accumulator registers need no reset: they are only read in BUSY/DONE.
   always_ff @(posedge clk) begin
      ma_q  <= ma_d;
      mb_q  <= mb_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
   end

   always_comb begin
      state_d  = state_q;
      ma_d     = ma_q;
      mb_d     = mb_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      stall    = 1'b0;
      mul_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_mul && !FlushE) begin
               stall   = 1'b1;
               ma_d    = src_a;
               mb_d    = src_b;
               acc_d   = '0;
               cnt_d   = SH_W'(XLEN - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (mb_q[0]) acc_d = acc_q + ma_q;
            ma_d  = ma_q << 1;
            mb_d  = mb_q >> 1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = DONE;
         end
         DONE: begin
            mul_done = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (FlushE) begin
         state_d = IDLE;
         stall   = 1'b0;
      end
   end

   // Gate with reset so an asserted reset releases the hazard unit immediately.
   assign StallE  = stall && rst;
   assign mul_res = acc_q;
`else
   assign StallE   = 1'b0;
   assign mul_done = 1'b0;
   assign mul_res  = '0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ResultSrcM <= '0;
         RdM        <= '0;
         ALUResultM <= '0;
         WriteDataM <= '0;
         PCPlus4M   <= '0;
      end else if (FlushE || StallE) begin
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ResultSrcM <= '0;
         RdM        <= '0;
         ALUResultM <= '0;
         WriteDataM <= '0;
         PCPlus4M   <= '0;
      end else begin
         RegWriteM  <= RegWriteE;
         MemWriteM  <= MemWriteE;
         ResultSrcM <= ResultSrcE;
         RdM        <= RdE;
         ALUResultM <= alu_res;
         WriteDataM <= write_data;
         PCPlus4M   <= PCPlus4E;
      end
   end

endmodule
